// File: rtl/common_dffram_fifo_ctrl.sv
// Synchronous FIFO controller over a flip-flop storage array with asynchronous read.
// Optional same-cycle empty bypass is compiled in with COMMON_DFFRAM_FIFO_CTRL_BYPASS_EN.
module common_dffram_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass_take;
    logic wr_en;
    logic rd_adv;

    assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_addr == rd_addr) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    assign s_ready = !full;
    assign push    = s_valid & s_ready;

`ifdef COMMON_DFFRAM_FIFO_CTRL_BYPASS_EN
    logic bypass_active;

    // An empty FIFO forwards the producer straight to the consumer.
    assign bypass_active = empty & !flush;
    assign m_valid       = bypass_active ? s_valid : !empty;
    assign m_data        = bypass_active ? s_data  : storage[rd_addr];
    assign bypass_take   = bypass_active & s_valid & m_ready;
`else
    assign m_valid     = !empty;
    assign m_data      = storage[rd_addr];
    assign bypass_take = 1'b0;
`endif

    assign pop    = m_valid & m_ready;
    assign wr_en  = push & !bypass_take;
    assign rd_adv = pop & !empty;

    assign count = wr_ptr - rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // NOTE: storage is reset deliberately so m_data reads as zero after reset; it costs a reset net per bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (wr_en && !flush) begin
            storage[wr_addr] <= s_data;
        end
    end

endmodule

// File: tb/tb_common_dffram_fifo_ctrl.sv
// Directed self-checking bench for common_dffram_fifo_ctrl at DATA_WIDTH=8, ADDR_WIDTH=2.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_common_dffram_fifo_ctrl;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 2;

    logic                  clk;
    logic                  reset;
    logic                  flush;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH:0]   count;

    int check_count = 0;
    int pass_count  = 0;

    common_dffram_fifo_ctrl #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push_one(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    logic [7:0] fill_vals [4];
    logic [7:0] drain_vals [4];
    logic [7:0] sim_in [3];
    logic [7:0] sim_out [5];

    initial begin
        fill_vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain_vals = '{8'h33, 8'h44, 8'h55, 8'h66};
        sim_in     = '{8'hB1, 8'hB2, 8'hB3};
        sim_out    = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hB3};

        reset   = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_count",   32'(count),   32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);

        // Fill to capacity with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            push_one(fill_vals[i]);
        end
        s_valid = 1'b1;
        s_data  = 8'h99;
        settle();
        check("fill_count",   32'(count),   32'd4);
        check("fill_s_ready", 32'(s_ready), 32'd0);
        check("fill_m_valid", 32'(m_valid), 32'd1);
        check("fill_m_data",  32'(m_data),  32'h11);
        tick();
        s_valid = 1'b0;
        settle();
        check("fill_5th_rejected", 32'(count), 32'd4);

        // Pop two, refill two across the storage boundary, then drain.
        m_ready = 1'b1;
        settle();
        check("pop0_data", 32'(m_data), 32'h11);
        tick();
        settle();
        check("pop1_data", 32'(m_data), 32'h22);
        tick();
        m_ready = 1'b0;
        settle();
        check("pop2_count", 32'(count), 32'd2);
        push_one(8'h55);
        push_one(8'h66);
        settle();
        check("refill_count", 32'(count), 32'd4);
        check("refill_s_ready", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("drain%0d_valid", i), 32'(m_valid), 32'd1);
            check($sformatf("drain%0d_data", i),  32'(m_data),  32'(drain_vals[i]));
            tick();
        end
        m_ready = 1'b0;
        settle();
        check("drain_count",   32'(count),   32'd0);
        check("drain_m_valid", 32'(m_valid), 32'd0);

        // Simultaneous push and pop at occupancy 2.
        push_one(8'hA1);
        push_one(8'hA2);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = sim_in[i];
            settle();
            check($sformatf("sim%0d_data", i), 32'(m_data), 32'(sim_out[i]));
            tick();
            check($sformatf("sim%0d_count", i), 32'(count), 32'd2);
        end
        s_valid = 1'b0;
        for (int i = 3; i < 5; i++) begin
            settle();
            check($sformatf("sim%0d_data", i), 32'(m_data), 32'(sim_out[i]));
            tick();
        end
        m_ready = 1'b0;
        settle();
        check("sim_end_count", 32'(count), 32'd0);

        // Flush with a concurrent push: the push is dropped.
        push_one(8'hC1);
        push_one(8'hC2);
        push_one(8'hC3);
        settle();
        check("pre_flush_count", 32'(count), 32'd3);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hC4;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        settle();
        check("flush_count",   32'(count),   32'd0);
        check("flush_m_valid", 32'(m_valid), 32'd0);
        check("flush_s_ready", 32'(s_ready), 32'd1);
        push_one(8'hD1);
        settle();
        check("post_flush_data", 32'(m_data), 32'hD1);

        // Reset mid-stream with a push in the same cycle.
        push_one(8'hD2);
        settle();
        check("pre_reset_count", 32'(count), 32'd2);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hD3;
        m_ready = 1'b1;
        tick();
        reset   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        settle();
        check("midrst_count",   32'(count),   32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data",  32'(m_data),  32'd0);

        // Empty FIFO offered an entry while the consumer is ready.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        m_ready = 1'b1;
        settle();
`ifdef COMMON_DFFRAM_FIFO_CTRL_BYPASS_EN
        check("byp_m_valid", 32'(m_valid), 32'd1);
        check("byp_m_data",  32'(m_data),  32'hA5);
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        settle();
        check("byp_count",   32'(count),   32'd0);
        check("byp_m_valid_after", 32'(m_valid), 32'd0);
`else
        check("lat_m_valid_same", 32'(m_valid), 32'd0);
        tick();
        s_valid = 1'b0;
        settle();
        check("lat_m_valid_next", 32'(m_valid), 32'd1);
        check("lat_m_data_next",  32'(m_data),  32'hA5);
        check("lat_count_next",   32'(count),   32'd1);
        tick();
        m_ready = 1'b0;
        settle();
        check("lat_count_drained", 32'(count), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
